// File: rtl/param_systolic_conv_engine_if.sv
// Result stream bundle for the convolution engine.
// Master drives valid/data/row/col; slave returns ready.
interface param_systolic_conv_engine_if #(
    parameter int OUT_W = 8,
    parameter int IDX_W = 1
);
    logic             valid;
    logic             ready;
    logic [OUT_W-1:0] data;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;

    modport master (
        output valid, data, row, col,
        input  ready
    );

    modport slave (
        input  valid, data, row, col,
        output ready
    );
endinterface

// File: rtl/param_systolic_conv_engine.sv
// Parametrised K x K valid convolution over an IN_DIM tile.
// One row of OUT_DIM MAC lanes is stepped over the filter taps.
module param_systolic_conv_engine #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 8,
    parameter int IN_DIM = 4,
    parameter int K      = 3,
    parameter int SAT    = 1,
    localparam int AW =
        (IN_DIM * IN_DIM > 1) ? $clog2(IN_DIM * IN_DIM) : 1,
    localparam int IW =
        (IN_DIM - K + 1 > 1) ? $clog2(IN_DIM - K + 1) : 1
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              ld_en,
    input  logic              ld_sel,
    input  logic [AW-1:0]     ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    param_systolic_conv_engine_if.master out
);
    localparam int OUT_DIM = IN_DIM - K + 1;
    localparam int NT      = K * K;
    localparam int ACC_W   = 2 * DATA_W + $clog2(NT);
    localparam int TW      = (NT > 1) ? $clog2(NT) : 1;
    localparam int KW      = (K > 1) ? $clog2(K) : 1;
    localparam int EW      = ACC_W + OUT_W;

    typedef enum logic [1:0] {
        IDLE, COMPUTE, DRAIN, FINISH
    } state_t;

    state_t state;

    logic [DATA_W-1:0] in_mem  [IN_DIM*IN_DIM];
    logic [DATA_W-1:0] flt_mem [NT];
    logic [ACC_W-1:0]  acc     [OUT_DIM];
    logic [ACC_W-1:0]  acc_nxt [OUT_DIM];

    logic [TW-1:0] t;
    logic [KW-1:0] kr;
    logic [KW-1:0] kc;
    logic [IW-1:0] r;
    logic [IW-1:0] lane;
    logic [IW-1:0] nlane;

    assign nlane = lane + 1'b1;

    function automatic logic [OUT_W-1:0] cvt(
        input logic [ACC_W-1:0] a
    );
        logic [EW-1:0] e;
        e = EW'(a);
        if (SAT != 0 && (e >> OUT_W) != '0)
            return '1;
        return e[OUT_W-1:0];
    endfunction

    function automatic logic big(
        input logic [ACC_W-1:0] a
    );
        return (EW'(a) >> OUT_W) != '0;
    endfunction

    // Memories carry no reset; they are only written while idle.
    always_ff @(posedge clk_in) begin
        if (ld_en && state == IDLE) begin
            if (!ld_sel)
                in_mem[ld_addr] <= ld_data;
            else if (int'(ld_addr) < NT)
                flt_mem[TW'(ld_addr)] <= ld_data;
        end
    end

    always_comb begin
        for (int j = 0; j < OUT_DIM; j++) begin
            acc_nxt[j] = acc[j]
                + ACC_W'(in_mem[AW'((int'(r) + int'(kr))
                    * IN_DIM + j + int'(kc))])
                * ACC_W'(flt_mem[t]);
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            out.valid <= 1'b0;
            out.data  <= '0;
            out.row   <= '0;
            out.col   <= '0;
            t         <= '0;
            kr        <= '0;
            kc        <= '0;
            r         <= '0;
            lane      <= '0;
            for (int j = 0; j < OUT_DIM; j++)
                acc[j] <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= COMPUTE;
                        busy  <= 1'b1;
                        ovf   <= 1'b0;
                        r     <= '0;
                        t     <= '0;
                        kr    <= '0;
                        kc    <= '0;
                        for (int j = 0; j < OUT_DIM; j++)
                            acc[j] <= '0;
                    end
                end
                COMPUTE: begin
                    for (int j = 0; j < OUT_DIM; j++)
                        acc[j] <= acc_nxt[j];
                    // Lane 0 is presented on the same edge as the last tap.
                    if (t == TW'(NT - 1)) begin
                        state     <= DRAIN;
                        t         <= '0;
                        kr        <= '0;
                        kc        <= '0;
                        lane      <= '0;
                        out.valid <= 1'b1;
                        out.data  <= cvt(acc_nxt[0]);
                        out.row   <= r;
                        out.col   <= '0;
                        if (big(acc_nxt[0]))
                            ovf <= 1'b1;
                    end else begin
                        t <= t + 1'b1;
                        if (kc == KW'(K - 1)) begin
                            kc <= '0;
                            kr <= kr + 1'b1;
                        end else begin
                            kc <= kc + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out.ready) begin
                        if (lane == IW'(OUT_DIM - 1)) begin
                            out.valid <= 1'b0;
                            for (int j = 0; j < OUT_DIM; j++)
                                acc[j] <= '0;
                            if (r == IW'(OUT_DIM - 1)) begin
                                state <= FINISH;
                            end else begin
                                r     <= r + 1'b1;
                                state <= COMPUTE;
                            end
                        end else begin
                            lane     <= nlane;
                            out.col  <= nlane;
                            out.data <= cvt(acc[nlane]);
                            if (big(acc[nlane]))
                                ovf <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_param_systolic_conv_engine.sv
// Scoreboard bench: dut0 default, dut1 SAT=0, dut2 5x5 K=1 16-bit.
// Expected results are queued on issue and popped by a monitor.
module tb_param_systolic_conv_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  ld_en;
    logic [2:0]  start;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [2:0]  ovf;
    logic        ld_sel;
    logic [4:0]  ld_addr;
    logic [15:0] ld_data;
    logic        rdy;
    logic        rdy_fix;
    bit          rnd_mode;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int row;
        int col;
        int data;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int hold_d[3];
    bit hold_v[3];

    param_systolic_conv_engine_if #(.OUT_W(8), .IDX_W(1)) ob0 ();
    param_systolic_conv_engine_if #(.OUT_W(8), .IDX_W(1)) ob1 ();
    param_systolic_conv_engine_if #(.OUT_W(16), .IDX_W(3)) ob2 ();

    assign ob0.ready = rdy;
    assign ob1.ready = rdy;
    assign ob2.ready = rdy;

    param_systolic_conv_engine dut0 (
        .clk_in (clk),
        .rst    (rst),
        .ld_en  (ld_en[0]),
        .ld_sel (ld_sel),
        .ld_addr(ld_addr[3:0]),
        .ld_data(ld_data[7:0]),
        .start  (start[0]),
        .busy   (busy[0]),
        .done   (done[0]),
        .ovf    (ovf[0]),
        .out    (ob0)
    );

    param_systolic_conv_engine #(.SAT(0)) dut1 (
        .clk_in (clk),
        .rst    (rst),
        .ld_en  (ld_en[1]),
        .ld_sel (ld_sel),
        .ld_addr(ld_addr[3:0]),
        .ld_data(ld_data[7:0]),
        .start  (start[1]),
        .busy   (busy[1]),
        .done   (done[1]),
        .ovf    (ovf[1]),
        .out    (ob1)
    );

    param_systolic_conv_engine #(
        .OUT_W(16), .IN_DIM(5), .K(1)
    ) dut2 (
        .clk_in (clk),
        .rst    (rst),
        .ld_en  (ld_en[2]),
        .ld_sel (ld_sel),
        .ld_addr(ld_addr),
        .ld_data(ld_data[7:0]),
        .start  (start[2]),
        .busy   (busy[2]),
        .done   (done[2]),
        .ovf    (ovf[2]),
        .out    (ob2)
    );

    task automatic cmp(string nm, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, req);
        end
    endtask

    task automatic push(int d, int row, int col, int data);
        exp_t e;
        e.row  = row;
        e.col  = col;
        e.data = data;
        case (d)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic mon(int d, logic v, logic rd,
                       int row, int col, int data);
        exp_t e;
        bit   got;
        if (hold_v[d] && v)
            cmp($sformatf("hold%0d", d), data, hold_d[d]);
        hold_v[d] = v && !rd;
        hold_d[d] = data;
        if (v && rd) begin
            got = 1'b0;
            if (d == 0 && q0.size() > 0) begin
                e = q0.pop_front(); got = 1'b1;
            end else if (d == 1 && q1.size() > 0) begin
                e = q1.pop_front(); got = 1'b1;
            end else if (d == 2 && q2.size() > 0) begin
                e = q2.pop_front(); got = 1'b1;
            end
            if (!got) begin
                total++;
                bad++;
                $display("FAIL extra%0d: got %0d want none",
                         d, data);
            end else begin
                cmp($sformatf("data%0d", d), data, e.data);
                cmp($sformatf("row%0d", d), row, e.row);
                cmp($sformatf("col%0d", d), col, e.col);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            hold_v = '{default: 1'b0};
        end else begin
            mon(0, ob0.valid, ob0.ready, int'(ob0.row),
                int'(ob0.col), int'(ob0.data));
            mon(1, ob1.valid, ob1.ready, int'(ob1.row),
                int'(ob1.col), int'(ob1.data));
            mon(2, ob2.valid, ob2.ready, int'(ob2.row),
                int'(ob2.col), int'(ob2.data));
        end
    end

    initial begin
        rdy = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (rnd_mode)
                rdy = 1'($urandom_range(0, 1));
            else
                rdy = rdy_fix;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(logic [2:0] m, logic sel, int a, int v);
        ld_en   = m;
        ld_sel  = sel;
        ld_addr = 5'(a);
        ld_data = 16'(v);
        tick();
        ld_en = '0;
    endtask

    task automatic load_base(logic [2:0] m);
        for (int i = 0; i < 16; i++)
            load(m, 1'b0, i, i + 1);
        for (int i = 0; i < 9; i++)
            load(m, 1'b1, i, 1);
    endtask

    task automatic push_base();
        push(0, 0, 0, 54);
        push(0, 0, 1, 63);
        push(0, 1, 0, 90);
        push(0, 1, 1, 99);
    endtask

    task automatic run(logic [2:0] m, int d, int lat);
        int n;
        n = 0;
        start = m;
        tick();
        start = '0;
        cmp("busy_on", int'(busy[d]), 1);
        while (!done[d] && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) begin
            total++;
            bad++;
            $display("FAIL timeout: got %0d want done", n);
        end else if (lat >= 0) begin
            cmp("latency", n, lat);
        end
    endtask

    initial begin
        int n;
        rst      = 1'b0;
        rdy_fix  = 1'b1;
        rnd_mode = 1'b0;
        ld_en    = '0;
        start    = '0;
        ld_sel   = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
        tick();
        tick();
        cmp("rst_busy", int'(busy), 0);
        cmp("rst_ovf", int'(ovf), 0);
        cmp("rst_done", int'(done), 0);
        cmp("rst_valid", int'(ob0.valid), 0);
        cmp("rst_data", int'(ob0.data), 0);
        rst = 1'b1;
        tick();

        // Baseline run with ready held high.
        load_base(3'b001);
        push_base();
        run(3'b001, 0, 23);
        cmp("ovf_base", int'(ovf[0]), 0);
        cmp("q_base", q0.size(), 0);
        tick();
        cmp("busy_off", int'(busy[0]), 0);

        // Same data under random backpressure.
        rnd_mode = 1'b1;
        push_base();
        run(3'b001, 0, -1);
        cmp("q_bp", q0.size(), 0);
        rnd_mode = 1'b0;
        tick();

        // Overflow: saturating and truncating variants.
        for (int i = 0; i < 16; i++)
            load(3'b011, 1'b0, i, 255);
        for (int i = 0; i < 9; i++)
            load(3'b011, 1'b1, i, 255);
        for (int i = 0; i < 4; i++) begin
            push(0, i / 2, i % 2, 255);
            push(1, i / 2, i % 2, 9);
        end
        run(3'b011, 0, 23);
        cmp("ovf_sat", int'(ovf[0]), 1);
        cmp("ovf_trunc", int'(ovf[1]), 1);
        cmp("q_sat", q0.size(), 0);
        cmp("q_trunc", q1.size(), 0);

        // Loads and start while busy must be ignored.
        load_base(3'b001);
        push_base();
        fork
            run(3'b001, 0, 23);
            begin
                tick();
                tick();
                ld_en   = 3'b001;
                ld_sel  = 1'b0;
                ld_addr = '0;
                ld_data = 16'd200;
                tick();
                ld_sel = 1'b1;
                tick();
                ld_en = '0;
                start = 3'b001;
                tick();
                start = '0;
            end
        join
        cmp("ovf_clr", int'(ovf[0]), 0);
        tick();
        tick();
        cmp("no_rerun", int'(busy[0]), 0);
        push_base();
        run(3'b001, 0, 23);
        cmp("q_ign", q0.size(), 0);

        // Reset while row 0 is draining.
        rdy_fix = 1'b0;
        tick();
        start = 3'b001;
        tick();
        start = '0;
        n = 0;
        while (!ob0.valid && n < 50) begin
            tick();
            n++;
        end
        cmp("drain_seen", int'(ob0.valid), 1);
        #2;
        rst = 1'b0;
        #1;
        cmp("mid_valid", int'(ob0.valid), 0);
        cmp("mid_busy", int'(busy[0]), 0);
        cmp("mid_ovf", int'(ovf[0]), 0);
        tick();
        rst = 1'b1;
        rdy_fix = 1'b1;
        tick();
        load_base(3'b001);
        push_base();
        run(3'b001, 0, 23);
        cmp("q_rst", q0.size(), 0);

        // K=1 elementwise scale on a 5x5 tile.
        for (int i = 0; i < 25; i++)
            load(3'b100, 1'b0, i, i);
        load(3'b100, 1'b1, 0, 3);
        load(3'b100, 1'b1, 1, 7);
        for (int i = 0; i < 25; i++)
            push(2, i / 5, i % 5, 3 * i);
        run(3'b100, 2, 31);
        cmp("ovf_k1", int'(ovf[2]), 0);
        cmp("q_k1", q2.size(), 0);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/param_systolic_conv_engine.md
Name: param_systolic_conv_engine

Overview:
- Parametrised successor to the fixed 2x2/3x3 systolic convolution block.
- Computes a valid (no-padding) 2-D convolution of an IN_DIM x IN_DIM unsigned input tile with a K x K unsigned filter.
- Uses a row of OUT_DIM = IN_DIM-K+1 MAC lanes that are time-multiplexed over the filter taps.
- Adds three things the fixed block lacks:
  - a write port for loading input and filter;
  - a start/busy/done control protocol;
  - a backpressured output stream with a selectable saturate or truncate mode.

Parameters:
DATA_W, 8, width of input and filter elements (unsigned)
OUT_W, 8, width of emitted results
IN_DIM, 4, input tile edge; must satisfy IN_DIM >= K
K, 3, filter edge; must be >= 1
SAT, 1, 1 = saturate result to 2^OUT_W-1; 0 = keep low OUT_W bits

Ports:
clk_in  in  1  clock
rst  in  1  reset, asynchronous, active-low
ld_en  in  1  load strobe
ld_sel  in  1  0 = input memory, 1 = filter memory
ld_addr  in  clog2(IN_DIM*IN_DIM)  row-major element index
ld_data  in  DATA_W  element value
start  in  1  begin computation (single-cycle pulse)
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse after the last result is accepted
out_valid  out  1  result available
out_ready  in  1  consumer accepts the result
out_data  out  OUT_W  result value
out_row  out  clog2(OUT_DIM)  output row index
out_col  out  clog2(OUT_DIM)  output column index
ovf  out  1  sticky; set if any result overflowed OUT_W during this run

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; busy, done, out_valid and ovf are 0; out_data, out_row, out_col and all accumulators are 0.
  - Memory contents are undefined after reset; the bench must reload before use.
- Load:
  - When ld_en=1 and state=IDLE, ld_data is written on the clock edge to input[ld_addr] (ld_sel=0) or filter[ld_addr] (ld_sel=1).
  - Filter writes with ld_addr >= K*K are ignored.
  - ld_en is ignored in every state other than IDLE.
- Arithmetic:
  - ACC_W = 2*DATA_W + clog2(K*K); the accumulator never wraps.
  - Result conversion: SAT=1 clamps values >2^OUT_W-1 to all-ones; SAT=0 truncates to the low OUT_W bits.
  - In both modes, ovf is set when a converted result had any nonzero bits above OUT_W. ovf is cleared on start acceptance.
- State machine (IDLE, COMPUTE, DRAIN, FINISH):
  - IDLE: start=1 → COMPUTE. On acceptance: row r=0, tap t=0, accumulators cleared, busy=1 on the next cycle. start is ignored outside IDLE.
  - COMPUTE: one tap per cycle for t=0..K*K-1, with kr=t/K and kc=t%K. Lane j adds input[(r+kr)*IN_DIM + j+kc] * filter[t]. After tap K*K-1 → DRAIN. This takes exactly K*K cycles.
  - DRAIN:
    - Emits lanes j=0..OUT_DIM-1 in order, with out_row=r and out_col=j.
    - out_valid stays high while results remain, and out_data, out_row and out_col are held stable until out_valid && out_ready.
    - No result is dropped or duplicated under arbitrary out_ready patterns.
    - After the last lane is accepted: if r<OUT_DIM-1, then r++, accumulators are cleared and the state returns to COMPUTE; otherwise → FINISH.
  - FINISH: done=1 for one cycle, busy=0 from the next cycle, → IDLE.
- Latency with out_ready held at 1:
  - Total = OUT_DIM*(K*K + OUT_DIM) + 1 cycles from start acceptance to done.
  - Default parameters: 2*(9+2)+1 = 23 cycles.
- Boundary cases:
  - K=IN_DIM: a single output, OUT_DIM=1.
  - K=1: an elementwise scale; the whole tile streams out.
- Reset asserted mid-run: immediate return to reset values; no done pulse is produced.

Test Plan:
- Default parameters; input = 1..16 row-major; filter all 1s; start; out_ready=1 → stream (0,0)=54, (0,1)=63, (1,0)=90, (1,1)=99; done exactly 23 cycles after start acceptance; ovf=0.
- Same data; out_ready toggled in a pseudo-random pattern → the same four values in the same order; out_data held stable while out_valid && !out_ready; done only after the 4th handshake.
- All inputs 255, filter all 255, SAT=1 → every result 255 and ovf=1; rerun with SAT=0 → every result 9 (585225 mod 256) and ovf=1.
- ld_en writes and a second start pulse issued while busy → memory unchanged and the run unaffected; results match the first scenario.
- Reset asserted during DRAIN of row 0 → out_valid, busy and ovf drop asynchronously; after reload and start, the results of the first scenario are reproduced.
- IN_DIM=5, K=1, OUT_W=16, filter[0]=3, input=0..24 → 25 results equal to 3*input in row-major order; filter write to addr 1 is ignored.
